// File: rtl/time_pkg.sv
// Shared types and constants for the time-setting digit entry path.
package time_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned VAL_W      = 7;
    localparam int unsigned HOUR_W     = 5;
    localparam int unsigned MINSEC_W   = 6;
    localparam int unsigned FIELD_W    = 2;

    localparam int unsigned KEY_CLR    = 10;
    localparam int unsigned KEY_SHARP  = 11;
    localparam int unsigned HOUR_MAX   = 23;
    localparam int unsigned MINSEC_MAX = 59;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        CHECK = 2'd2
    } state_t;

    typedef enum logic [FIELD_W-1:0] {
        FLD_NONE = 2'd0,
        FLD_HOUR = 2'd1,
        FLD_MIN  = 2'd2,
        FLD_SEC  = 2'd3
    } field_t;

    // True for decimal key codes 0-9.
    function automatic logic is_digit(input logic [DIGIT_W-1:0] code);
        return code <= DIGIT_W'(9);
    endfunction

endpackage

// File: rtl/bcd2_field.sv
// Two-digit BCD staging register with binary value and range compare.
module bcd2_field
    import time_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               shift,
    input  logic               clear,
    input  logic               zero_init,
    input  logic [DIGIT_W-1:0] digit,
    input  logic [VAL_W-1:0]   max_val,
    output logic [VAL_W-1:0]   value_c,
    output logic               le_max_c
);

    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;

    // Shift new digit into ones, old ones into tens; clear wins over shift.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tens <= '0;
            ones <= '0;
        end else if (clear || zero_init) begin
            tens <= '0;
            ones <= '0;
        end else if (shift) begin
            tens <= ones;
            ones <= digit;
        end
    end

    // Tens nibble may hold up to 9, so the value spans 0-99.
    assign value_c  = VAL_W'(tens) * VAL_W'(10) + VAL_W'(ones);
    assign le_max_c = (value_c <= max_val);

endmodule

// File: rtl/time_set_entry.sv
// Captures keypad digits into hour/min/sec staging and commits them after a range check.
module time_set_entry
    import time_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                key_valid,
    input  logic [DIGIT_W-1:0]  key_code,
    input  logic                hour_en,
    input  logic                min_en,
    input  logic                sec_en,
    input  logic                complete_setting,
    output logic [HOUR_W-1:0]   hour,
    output logic [MINSEC_W-1:0] min,
    output logic [MINSEC_W-1:0] sec,
    output logic                set_valid,
    output logic                entry_err,
    output logic [FIELD_W-1:0]  active_field
);

    state_t                state;
    state_t                state_next;
    field_t                sel_fld;
    field_t                field_next;
    logic                  any_en;
    logic                  key_ok;
    logic                  zero_init;
    logic                  digit_key;
    logic                  clr_key;
    logic                  all_ok;
    logic [VAL_W-1:0]      hour_val;
    logic [VAL_W-1:0]      min_val;
    logic [VAL_W-1:0]      sec_val;
    logic                  hour_ok;
    logic                  min_ok;
    logic                  sec_ok;
    logic [HOUR_W-1:0]     hour_next;
    logic [MINSEC_W-1:0]   min_next;
    logic [MINSEC_W-1:0]   sec_next;
    logic                  set_valid_next;
    logic                  entry_err_next;

    assign any_en = hour_en | min_en | sec_en;
    assign all_ok = hour_ok & min_ok & sec_ok;

    // Field select with hour > min > sec priority.
    always_comb begin
        sel_fld = FLD_NONE;
        if (hour_en)     sel_fld = FLD_HOUR;
        else if (min_en) sel_fld = FLD_MIN;
        else if (sec_en) sel_fld = FLD_SEC;
    end

    // Keys only count in ENTRY and never alongside complete_setting.
    assign digit_key = key_valid & key_ok & is_digit(key_code);
    assign clr_key   = key_valid & key_ok & (key_code == DIGIT_W'(KEY_CLR));

    // Next state, staging controls and next output values.
    always_comb begin
        state_next     = state;
        zero_init      = 1'b0;
        key_ok         = 1'b0;
        hour_next      = hour;
        min_next       = min;
        sec_next       = sec;
        set_valid_next = 1'b0;
        entry_err_next = 1'b0;
        case (state)
            IDLE: begin
                if (complete_setting) begin
                    state_next = CHECK;
                end else if (any_en) begin
                    state_next = ENTRY;
                    zero_init  = 1'b1;
                end
            end
            ENTRY: begin
                key_ok = ~complete_setting;
                if (complete_setting) state_next = CHECK;
                else if (!any_en)     state_next = IDLE;
            end
            CHECK: begin
                state_next = IDLE;
                if (all_ok) begin
                    hour_next      = HOUR_W'(hour_val);
                    min_next       = MINSEC_W'(min_val);
                    sec_next       = MINSEC_W'(sec_val);
                    set_valid_next = 1'b1;
                end else begin
                    entry_err_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        field_next = (state_next == ENTRY) ? sel_fld : FLD_NONE;
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hour         <= '0;
            min          <= '0;
            sec          <= '0;
            set_valid    <= 1'b0;
            entry_err    <= 1'b0;
            active_field <= FLD_NONE;
        end else begin
            hour         <= hour_next;
            min          <= min_next;
            sec          <= sec_next;
            set_valid    <= set_valid_next;
            entry_err    <= entry_err_next;
            active_field <= field_next;
        end
    end

    bcd2_field u_hour (
        .clock     (clock),
        .reset     (reset),
        .shift     (digit_key & (sel_fld == FLD_HOUR)),
        .clear     (clr_key & (sel_fld == FLD_HOUR)),
        .zero_init (zero_init),
        .digit     (key_code),
        .max_val   (VAL_W'(HOUR_MAX)),
        .value_c   (hour_val),
        .le_max_c  (hour_ok)
    );

    bcd2_field u_min (
        .clock     (clock),
        .reset     (reset),
        .shift     (digit_key & (sel_fld == FLD_MIN)),
        .clear     (clr_key & (sel_fld == FLD_MIN)),
        .zero_init (zero_init),
        .digit     (key_code),
        .max_val   (VAL_W'(MINSEC_MAX)),
        .value_c   (min_val),
        .le_max_c  (min_ok)
    );

    bcd2_field u_sec (
        .clock     (clock),
        .reset     (reset),
        .shift     (digit_key & (sel_fld == FLD_SEC)),
        .clear     (clr_key & (sel_fld == FLD_SEC)),
        .zero_init (zero_init),
        .digit     (key_code),
        .max_val   (VAL_W'(MINSEC_MAX)),
        .value_c   (sec_val),
        .le_max_c  (sec_ok)
    );

endmodule
